mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit with the architectural HI/LO registers.
- Sits in the EX stage beside the combinational ALU and receives the same A/B operands.
- Executes mult/multu/div/divu with fixed latencies, handles mthi/mtlo writes and drives mfhi/mflo read data.
- Raises busy so hazard control stalls any later MD instruction until the result commits.

---
 rtl/mult_div_unit.sv | 146 ++++++++++++++
 tb/tb_mult_div_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at issue, held in pend_hi/pend_lo and committed after a fixed latency.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  op,
  input  logic        start,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] out
);

  typedef enum logic [1:0] {StIdle, StMult, StDiv} state_e;

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMfhi  = 4'd7;
  localparam logic [3:0] OpMflo  = 4'd8;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic        go;
  logic [63:0] a_s64, b_s64, prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, div_s, div_u;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

  assign busy = (state_q != StIdle);
  assign go   = start & ~cancel & ~busy;

  // Sign-extending to 64 bits lets one wide multiplier produce the exact signed product.
  assign a_s64  = {{32{A[31]}}, A};
  assign b_s64  = {{32{B[31]}}, B};
  assign prod_s = a_s64 * b_s64;
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide on magnitudes; a zero divisor is replaced by 1 to keep the datapath defined.
  assign a_neg = A[31];
  assign b_neg = B[31];
  assign a_mag = a_neg ? (32'd0 - A) : A;
  assign b_mag = b_neg ? (32'd0 - B) : B;
  assign div_s = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag = a_mag / div_s;
  assign r_mag = a_mag % div_s;
  assign q_s   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign r_s   = a_neg ? (32'd0 - r_mag) : r_mag;
  assign div_u = (B == 32'd0) ? 32'd1 : B;
  assign q_u   = A / div_u;
  assign r_u   = A % div_u;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          case (op)
            OpMult, OpMultu: begin
              pend_hi_d = (op == OpMult) ? prod_s[63:32] : prod_u[63:32];
              pend_lo_d = (op == OpMult) ? prod_s[31:0]  : prod_u[31:0];
              dz_d      = 1'b0;
              cnt_d     = 4'(MULT_CYCLES - 1);
              state_d   = StMult;
            end
            OpDiv, OpDivu: begin
              pend_hi_d = (op == OpDiv) ? r_s : r_u;
              pend_lo_d = (op == OpDiv) ? q_s : q_u;
              dz_d      = (B == 32'd0);
              cnt_d     = 4'(DIV_CYCLES - 1);
              state_d   = StDiv;
            end
            OpMthi:  hi_d = A;
            OpMtlo:  lo_d = A;
            default: ;
          endcase
        end
      end
      StMult, StDiv: begin
        if (cnt_q == 4'd0) begin
          if (!dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          dz_d    = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      dz_q      <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

  always_comb begin
    out = 32'd0;
    case (op)
      OpMfhi:  out = hi_q;
      OpMflo:  out = lo_q;
      default: out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a reference model queues expected HI/LO at issue,
// and each commit is popped and compared together with the observed busy length.
module tb_mult_div_unit;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk, rst_n;
  logic [31:0] A, B;
  logic [3:0]  op;
  logic        start, cancel;
  logic        busy;
  logic [31:0] hi_out, lo_out, out;

  exp_t        sb_q[$];
  logic [31:0] m_hi, m_lo, old_hi, old_lo;
  int          total, bad;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .op     (op),
    .start  (start),
    .cancel (cancel),
    .busy   (busy),
    .hi_out (hi_out),
    .lo_out (lo_out),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single cycle; the model updates at issue time.
  task automatic drive_go(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic c);
    longint      sa, sb, p, q, r;
    logic [63:0] u;
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1; cancel = c;
    if (!c) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
        4'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; sb_q.push_back({m_hi, m_lo}); end
        4'd2: begin
          u = {32'd0, a} * {32'd0, b}; m_hi = u[63:32]; m_lo = u[31:0];
          sb_q.push_back({m_hi, m_lo});
        end
        4'd3: begin
          if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
          sb_q.push_back({m_hi, m_lo});
        end
        4'd4: begin
          if (b != 0) begin m_lo = a / b; m_hi = a % b; end
          sb_q.push_back({m_hi, m_lo});
        end
        4'd5: m_hi = a;
        4'd6: m_lo = a;
        default: ;
      endcase
    end
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = 4'd0;
  endtask

  // Counts busy cycles (starting from base already seen), then pops and compares the commit.
  task automatic wait_done(input string tag, input int base, input int exp_cycles);
    int   n;
    exp_t e;
    n = base;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, n, exp_cycles);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_hi"}, hi_out, e.hi);
      check({tag, "_lo"}, lo_out, e.lo);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    m_hi = 0; m_lo = 0;
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = 4'd0; A = 0; B = 0;
    #3;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi_out, 32'd0);
    check("reset_lo", lo_out, 32'd0);
    check("reset_out", out, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Multiplies
    drive_go(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_done("multu", 0, 5);
    check("multu_hi_const", hi_out, 32'h0000_0001);
    drive_go(4'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
    wait_done("mult", 0, 5);
    check("mult_lo_const", lo_out, 32'hFFFF_FFEB);

    // Divides
    drive_go(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done("div_neg", 0, 10);
    check("div_neg_lo_const", lo_out, 32'hFFFF_FFFD);
    drive_go(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done("div_ovf", 0, 10);
    drive_go(4'd4, 32'd1000, 32'd7, 1'b0);
    wait_done("divu", 0, 10);
    drive_go(4'd5, 32'h11, 32'd0, 1'b0);
    drive_go(4'd6, 32'h22, 32'd0, 1'b0);
    drive_go(4'd4, 32'd7, 32'd0, 1'b0);
    wait_done("divu_zero", 0, 10);
    check("divu_zero_hi_const", hi_out, 32'h11);

    // Moves and reads
    drive_go(4'd5, 32'h1234_5678, 32'd0, 1'b0);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_hi", hi_out, 32'h1234_5678);
    @(negedge clk);
    check("mthi_busy_later", {31'd0, busy}, 32'd0);
    op = 4'd7; #1;
    check("mfhi_out", out, m_hi);
    op = 4'd8; #1;
    check("mflo_out", out, m_lo);
    op = 4'd9; #1;
    check("none_out", out, 32'd0);
    op = 4'd0;

    // Requests while busy are ignored
    old_lo = m_lo;
    drive_go(4'd1, 32'd5, 32'hFFFF_FFFA, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd7;
    @(negedge clk);
    op = 4'd6; A = 32'h0000_DEAD;
    @(negedge clk);
    check("busy_mtlo_ignored", lo_out, old_lo);
    start = 1'b0; op = 4'd0;
    wait_done("busy_ignore", 4, 5);
    @(negedge clk);
    check("busy_ignore_idle", {31'd0, busy}, 32'd0);

    // Cancel
    old_hi = hi_out; old_lo = lo_out;
    drive_go(4'd1, 32'd9, 32'd9, 1'b1);
    check("cancel_busy", {31'd0, busy}, 32'd0);
    check("cancel_hi", hi_out, old_hi);
    check("cancel_lo", lo_out, old_lo);
    drive_go(4'd2, 32'd123, 32'd456, 1'b0);
    cancel = 1'b1;
    wait_done("cancel_late", 0, 5);
    cancel = 1'b0;

    // Asynchronous reset mid-divide
    drive_go(4'd3, 32'd1000, 32'd7, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi_out, 32'd0);
    check("arst_lo", lo_out, 32'd0);
    sb_q.delete();
    m_hi = 0; m_lo = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_go(4'd2, 32'd3, 32'd4, 1'b0);
    wait_done("post_reset", 0, 5);
    check("post_reset_lo_const", lo_out, 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
